// File: rtl/c880_result_buffer_if.sv
// Upstream/downstream valid-ready handshake bundle for the c880 result buffer.
interface c880_result_buffer_if #(
  parameter int unsigned WIDTH = 26
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/c880_result_buffer.sv
// Show-ahead FIFO for c880 output vectors with a running MISR signature of
// every accepted word and a sticky overflow flag.
module c880_result_buffer #(
  parameter int unsigned     WIDTH = 26,
  parameter int unsigned     DEPTH = 4,
  parameter logic [WIDTH-1:0] POLY = 26'h0000047,
  localparam int unsigned    PW    = $clog2(DEPTH),
  localparam int unsigned    CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  c880_result_buffer_if.slave   bus,
  output logic [CW-1:0]         count,
  input  logic                  sig_clear,
  output logic [WIDTH-1:0]      sig,
  output logic                  ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] sig_base;
  logic             ovf_q, ovf_d;
  logic             rdy_en_q;
  logic             full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // rdy_en_q keeps in_ready low through reset and releases it one edge later.
  assign bus.in_ready  = rdy_en_q && !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rptr_q];

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign count = count_q;
  assign sig   = sig_q;
  assign ovf   = ovf_q;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    sig_d    = sig_q;
    ovf_d    = ovf_q;
    sig_base = sig_clear ? '0 : sig_q;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A clear coinciding with a push folds the word into a zero signature.
    if (push) begin
      sig_d = {sig_base[WIDTH-2:0], 1'b0}
            ^ (sig_base[WIDTH-1] ? POLY : '0)
            ^ bus.in_data;
    end else if (sig_clear) begin
      sig_d = '0;
    end

    if (bus.in_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sig_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.in_data;
  end

endmodule

// File: tb/tb_c880_result_buffer.sv
// Directed self-checking bench for c880_result_buffer.
module tb_c880_result_buffer;

  localparam int unsigned WIDTH = 26;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             sig_clear;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sig;
  logic             ovf;

  int unsigned n_checks;
  int unsigned n_errors;

  c880_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  c880_result_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .POLY  (26'h0000047)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .count     (count),
    .sig_clear (sig_clear),
    .sig       (sig),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    sig_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state, including across clock edges while rst is held.
    #2;
    chk("rst_count",    32'(count),         32'd0);
    chk("rst_out_valid",32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),  32'd0);
    chk("rst_sig",      32'(sig),           32'd0);
    chk("rst_ovf",      32'(ovf),           32'd0);
    chk("rst_out_data", 32'(bus.out_data),  32'd0);
    step();
    step();
    chk("rst_in_ready_held", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    step();
    chk("in_ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Fill with out_ready low; first word visible one edge after its push.
    push_word(26'h0000001);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_data",  32'(bus.out_data),  32'h1);
    push_word(26'h0000002);
    push_word(26'h0000003);
    push_word(26'h0000004);
    chk("full_count",    32'(count),        32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_sig",      32'(sig),          32'h2);

    // Overflow attempt while full.
    push_word(26'h3FFFFFF);
    chk("ovf_count", 32'(count),        32'd4);
    chk("ovf_set",   32'(ovf),          32'd1);
    chk("ovf_sig",   32'(sig),          32'h2);
    chk("ovf_head",  32'(bus.out_data), 32'h1);

    // Drain in order.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(bus.out_data), 32'(i + 1));
      step();
    end
    chk("drain_count", 32'(count),         32'd0);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_ovf",   32'(ovf),           32'd1);
    step();
    chk("empty_pop_count", 32'(count), 32'd0);
    bus.out_ready = 1'b0;

    sig_clear = 1'b1;
    step();
    sig_clear = 1'b0;
    chk("clear_sig",      32'(sig), 32'd0);
    chk("clear_keep_ovf", 32'(ovf), 32'd1);

    // Signature steps and clear priority.
    push_word(26'h2000000);
    chk("sig_a", 32'(sig), 32'h2000000);
    push_word(26'h0000000);
    chk("sig_b", 32'(sig), 32'h0000047);
    sig_clear = 1'b1;
    push_word(26'h0000005);
    chk("clr_push_sig", 32'(sig), 32'h0000005);
    step();
    sig_clear = 1'b0;
    chk("clr_nopush_sig", 32'(sig),   32'd0);
    chk("clr_count",      32'(count), 32'd3);

    bus.out_ready = 1'b1;
    chk("d3_0", 32'(bus.out_data), 32'h2000000);
    step();
    chk("d3_1", 32'(bus.out_data), 32'h0000000);
    step();
    chk("d3_2", 32'(bus.out_data), 32'h0000005);
    step();
    bus.out_ready = 1'b0;
    chk("d3_count", 32'(count), 32'd0);

    push_word(26'h2000000);
    push_word(26'h0000000);
    push_word(26'h0000001);
    chk("sig_c", 32'(sig), 32'h000008F);
    step();
    step();
    chk("stall_data",  32'(bus.out_data),  32'h2000000);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd3);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    32'(bus.out_valid), 32'd0);
    chk("arst_count",    32'(count),         32'd0);
    chk("arst_sig",      32'(sig),           32'd0);
    chk("arst_ovf",      32'(ovf),           32'd0);
    chk("arst_in_ready", 32'(bus.in_ready),  32'd0);
    chk("arst_data",     32'(bus.out_data),  32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_rel_ready0", 32'(bus.in_ready), 32'd0);
    step();
    chk("arst_rel_ready1", 32'(bus.in_ready), 32'd1);

    // Concurrent push/pop at count 2 across pointer wrap.
    push_word(26'd100);
    push_word(26'd101);
    chk("conc_start", 32'(count), 32'd2);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 26'(102 + i);
      chk("conc_data", 32'(bus.out_data), 32'(100 + i));
      step();
      chk("conc_count", 32'(count), 32'd2);
    end
    bus.in_valid = 1'b0;
    chk("conc_tail0", 32'(bus.out_data), 32'd110);
    step();
    chk("conc_tail1", 32'(bus.out_data), 32'd111);
    step();
    chk("conc_empty", 32'(bus.out_valid), 32'd0);
    chk("conc_ovf",   32'(ovf),           32'd0);
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
